lfsr_burst_ctrl: RTL and testbench

Command-driven controller that seeds, steps and drains an N-bit Fibonacci LFSR in bursts. A requester issues a (seed, count) command over a valid/ready channel. The block then emits exactly count LFSR states on a back-pressured output stream and flags whether the sequence wrapped to its seed. It sits between a test/pattern scheduler and any consumer of pseudo-random sequences, replacing free-running LFSR counters where sequence start, length and flow control must be controlled.

---
 rtl/lfsr_burst_ctrl.sv | 100 ++++++++++
 tb/tb_lfsr_burst_ctrl.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_burst_ctrl.sv
// Command-driven burst controller around an N-bit Fibonacci LFSR: seeds it,
// emits exactly cmd_count states on a back-pressured stream, reports wrap-to-seed.
module lfsr_burst_ctrl #(
    parameter int             N    = 3,
    parameter logic [N-1:0]   TAPS = 3'b110,
    parameter int             CW   = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [N-1:0]  cmd_seed,
    input  logic [CW-1:0] cmd_count,
    input  logic          abort,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_data,
    output logic          out_last,
    output logic          busy,
    output logic          done,
    output logic          wrap
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [N-1:0]  ONE_N  = {{(N-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] ONE_CW = {{(CW-1){1'b0}}, 1'b1};

    function automatic logic [N-1:0] lfsr_step(input logic [N-1:0] s);
        return {s[N-2:0], ^(s & TAPS)};
    endfunction

    // An all-zero seed would lock the LFSR, so it is promoted to 1.
    function automatic logic [N-1:0] safe_seed(input logic [N-1:0] s);
        return (s == '0) ? ONE_N : s;
    endfunction

    logic [1:0]    state;
    logic [N-1:0]  lfsr;
    logic [N-1:0]  seed_q;
    logic [CW-1:0] remaining;
    logic          wrap_q;
    logic [N-1:0]  lfsr_next;
    logic          beat;

    assign lfsr_next = lfsr_step(lfsr);
    assign beat      = (state == RUN) && out_ready;

    assign cmd_ready = (state == IDLE);
    assign out_valid = (state == RUN);
    assign out_data  = lfsr;
    assign out_last  = (state == RUN) && (remaining == ONE_CW);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign wrap      = wrap_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            lfsr      <= ONE_N;
            seed_q    <= ONE_N;
            remaining <= '0;
            wrap_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        lfsr      <= safe_seed(cmd_seed);
                        seed_q    <= safe_seed(cmd_seed);
                        remaining <= cmd_count;
                        wrap_q    <= 1'b0;
                        state     <= (cmd_count == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (beat) begin
                        lfsr      <= lfsr_next;
                        remaining <= remaining - ONE_CW;
                        if (lfsr_next == seed_q)
                            wrap_q <= 1'b1;
                        if (remaining == ONE_CW)
                            state <= DONE;
                    end
                    // A beat taken on the abort edge still counts as delivered.
                    if (abort)
                        state <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lfsr_burst_ctrl.sv
// Randomized self-checking bench for lfsr_burst_ctrl against a sequence-level model.
module tb_lfsr_burst_ctrl;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd_seed = 3'd0;
    logic [7:0] cmd_count = 8'd0;
    logic       abort = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [2:0] out_data;
    logic       out_last;
    logic       busy;
    logic       done;
    logic       wrap;

    lfsr_burst_ctrl #(.N(3), .TAPS(3'b110), .CW(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_seed(cmd_seed), .cmd_count(cmd_count), .abort(abort),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy), .done(done), .wrap(wrap)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Observations of one burst
    logic [2:0] obs_data[$];
    logic       obs_last[$];
    logic       obs_wrap[$];
    int         last_hs_cyc, done_cyc, first_valid_cyc, n_valid;
    logic       wrap_at_done, done_after, cr_after, held_ok, rdy_in_burst, timed_out;

    // Expected burst
    logic [2:0] exp_data[$];
    logic       exp_wrap[$];
    logic       exp_wrap_done;

    function automatic logic [2:0] model_next(input logic [2:0] s);
        int v;
        int fb;
        v  = int'(s);
        fb = $countones(s & 3'b110) % 2;
        return 3'(((v * 2) % 8) + fb);
    endfunction

    task automatic build_model(input logic [2:0] seed, input int n);
        logic [2:0] s0;
        logic [2:0] st;
        logic       w;
        exp_data.delete();
        exp_wrap.delete();
        s0 = (seed == 3'd0) ? 3'd1 : seed;
        st = s0;
        w  = 1'b0;
        for (int i = 0; i < n; i++) begin
            exp_data.push_back(st);
            exp_wrap.push_back(w);
            st = model_next(st);
            if (st == s0) w = 1'b1;
        end
        exp_wrap_done = w;
    endtask

    // mode: 0 ready always high, 1 ready toggling 1/0, 2 random ready.
    task automatic run_cmd(input logic [2:0] seed, input logic [7:0] count, input int mode,
                           input int abort_at, input bit hold_valid);
        int         hs;
        int         w;
        bit         stalled;
        bit         fin;
        logic       r;
        logic [2:0] pd;
        logic       pl;
        obs_data.delete(); obs_last.delete(); obs_wrap.delete();
        last_hs_cyc = -1; done_cyc = -1; first_valid_cyc = -1; n_valid = 0;
        wrap_at_done = 1'bx; done_after = 1'bx; cr_after = 1'bx;
        held_ok = 1'b1; rdy_in_burst = 1'b0; timed_out = 1'b1;
        hs = 0; stalled = 0; fin = 0; pd = '0; pl = 1'b0;
        @(negedge clk);
        w = 0;
        while (!cmd_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        cmd_valid = 1'b1; cmd_seed = seed; cmd_count = count;
        @(negedge clk);
        if (hold_valid) cmd_seed = ~seed;
        else cmd_valid = 1'b0;
        for (int cyc = 0; cyc < 2000 && !fin; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (done) begin
                done_cyc = cyc; wrap_at_done = wrap;
                cmd_valid = 1'b0; out_ready = 1'b0; abort = 1'b0;
                @(negedge clk);
                done_after = done; cr_after = cmd_ready;
                timed_out = 1'b0;
                fin = 1;
            end else begin
                if (cmd_ready) rdy_in_burst = 1'b1;
                if (out_valid) begin
                    n_valid++;
                    if (first_valid_cyc < 0) first_valid_cyc = cyc;
                    if (stalled && (out_data !== pd || out_last !== pl)) held_ok = 1'b0;
                    r = (mode == 0) ? 1'b1 : (mode == 1) ? ((cyc % 2) == 0) : 1'($urandom % 2);
                    out_ready = r;
                    abort = (abort_at != 0 && hs + 1 == abort_at && r);
                    if (r) begin
                        obs_data.push_back(out_data);
                        obs_last.push_back(out_last);
                        obs_wrap.push_back(wrap);
                        hs++;
                        last_hs_cyc = cyc;
                        stalled = 0;
                    end else begin
                        stalled = 1;
                    end
                    pd = out_data; pl = out_last;
                end else begin
                    out_ready = 1'b0; abort = 1'b0;
                end
            end
        end
        cmd_valid = 1'b0; out_ready = 1'b0; abort = 1'b0;
    endtask

    task automatic test_reset;
        #12;
        n_checks++;
        if ({cmd_ready, out_valid, out_last, busy, done, wrap} !== 6'b100000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 100000", {cmd_ready, out_valid, out_last, busy, done, wrap});
        end
        n_checks++;
        if (out_data !== 3'd1) begin
            n_fail++; $display("FAIL reset_data: got %0d expected 1", out_data);
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_full_period;
        run_cmd(3'd1, 8'd7, 0, 0, 0);
        build_model(3'd1, 7);
        n_checks++;
        if (timed_out !== 1'b0 || obs_data.size() != 7) begin
            n_fail++; $display("FAIL full_beats: got %0d beats expected 7 (timeout %b)", obs_data.size(), timed_out);
        end else begin
            for (int i = 0; i < 7; i++) begin
                n_checks++;
                if (obs_data[i] !== exp_data[i] || obs_last[i] !== (i == 6)) begin
                    n_fail++;
                    $display("FAIL full_beat%0d: got %0d/%b expected %0d/%b", i, obs_data[i], obs_last[i], exp_data[i], i == 6);
                end
            end
        end
        n_checks++;
        if (first_valid_cyc !== 0 || last_hs_cyc !== 6) begin
            n_fail++; $display("FAIL full_timing: got first %0d last %0d expected 0 6", first_valid_cyc, last_hs_cyc);
        end
        n_checks++;
        if (done_cyc - last_hs_cyc !== 1 || done_after !== 1'b0 || cr_after !== 1'b1) begin
            n_fail++;
            $display("FAIL full_done: got lat %0d done2 %b rdy %b expected 1 0 1", done_cyc - last_hs_cyc, done_after, cr_after);
        end
        n_checks++;
        if (wrap_at_done !== 1'b1) begin
            n_fail++; $display("FAIL full_wrap: got %b expected 1", wrap_at_done);
        end
    endtask

    task automatic test_stall;
        run_cmd(3'd5, 8'd3, 1, 0, 0);
        build_model(3'd5, 3);
        n_checks++;
        if (obs_data.size() != 3) begin
            n_fail++; $display("FAIL stall_beats: got %0d expected 3", obs_data.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (obs_data[i] !== exp_data[i] || obs_last[i] !== (i == 2)) begin
                    n_fail++;
                    $display("FAIL stall_beat%0d: got %0d/%b expected %0d/%b", i, obs_data[i], obs_last[i], exp_data[i], i == 2);
                end
            end
        end
        n_checks++;
        if (held_ok !== 1'b1) begin
            n_fail++; $display("FAIL stall_hold: got %b expected 1", held_ok);
        end
        n_checks++;
        if (wrap_at_done !== 1'b0 || timed_out !== 1'b0) begin
            n_fail++; $display("FAIL stall_wrap: got %b expected 0 (timeout %b)", wrap_at_done, timed_out);
        end
    endtask

    task automatic test_zero_seed;
        run_cmd(3'd0, 8'd2, 0, 0, 0);
        build_model(3'd0, 2);
        n_checks++;
        if (obs_data.size() != 2 || obs_data[0] !== exp_data[0] || obs_data[1] !== exp_data[1]) begin
            n_fail++;
            $display("FAIL zero_seed: got %0d beats first %0d expected 2 beats %0d,%0d",
                     obs_data.size(), (obs_data.size() > 0) ? obs_data[0] : 3'bx, exp_data[0], exp_data[1]);
        end
    endtask

    task automatic test_count8;
        run_cmd(3'd1, 8'd8, 2, 0, 0);
        build_model(3'd1, 8);
        n_checks++;
        if (obs_data.size() != 8) begin
            n_fail++; $display("FAIL c8_beats: got %0d expected 8", obs_data.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                n_checks++;
                if (obs_data[i] !== exp_data[i] || obs_wrap[i] !== exp_wrap[i]) begin
                    n_fail++;
                    $display("FAIL c8_beat%0d: got %0d wrap %b expected %0d wrap %b", i, obs_data[i], obs_wrap[i], exp_data[i], exp_wrap[i]);
                end
            end
        end
        n_checks++;
        if (wrap_at_done !== 1'b1 || held_ok !== 1'b1) begin
            n_fail++; $display("FAIL c8_end: got wrap %b hold %b expected 1 1", wrap_at_done, held_ok);
        end
    endtask

    task automatic test_count0;
        run_cmd(3'd3, 8'd0, 0, 0, 0);
        n_checks++;
        if (n_valid !== 0 || done_cyc !== 0) begin
            n_fail++; $display("FAIL c0_done: got valid %0d done_cyc %0d expected 0 0", n_valid, done_cyc);
        end
        n_checks++;
        if (done_after !== 1'b0 || cr_after !== 1'b1) begin
            n_fail++; $display("FAIL c0_return: got done %b rdy %b expected 0 1", done_after, cr_after);
        end
    endtask

    task automatic test_abort;
        run_cmd(3'd1, 8'd10, 0, 3, 1);
        build_model(3'd1, 3);
        n_checks++;
        if (obs_data.size() != 3) begin
            n_fail++; $display("FAIL abort_beats: got %0d expected 3", obs_data.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (obs_data[i] !== exp_data[i] || obs_last[i] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL abort_beat%0d: got %0d/%b expected %0d/0", i, obs_data[i], obs_last[i], exp_data[i]);
                end
            end
        end
        n_checks++;
        if (done_cyc - last_hs_cyc !== 1 || wrap_at_done !== 1'b0) begin
            n_fail++; $display("FAIL abort_done: got lat %0d wrap %b expected 1 0", done_cyc - last_hs_cyc, wrap_at_done);
        end
        n_checks++;
        if (rdy_in_burst !== 1'b0) begin
            n_fail++; $display("FAIL abort_cmd_ready: got %b expected 0", rdy_in_burst);
        end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_seed = 3'd3; cmd_count = 8'd20;
        @(negedge clk);
        cmd_valid = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || done !== 1'b0 || out_data !== 3'd1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid: got valid %b done %b data %0d busy %b expected 0 0 1 0", out_valid, done, out_data, busy);
        end
        @(negedge clk);
        reset_n = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        n_checks++;
        if (cmd_ready !== 1'b1 || done !== 1'b0) begin
            n_fail++; $display("FAIL rst_release: got rdy %b done %b expected 1 0", cmd_ready, done);
        end
        run_cmd(3'd6, 8'd4, 2, 0, 0);
        build_model(3'd6, 4);
        n_checks++;
        if (obs_data.size() != 4 || obs_data != exp_data || timed_out !== 1'b0) begin
            n_fail++; $display("FAIL rst_rerun: got %0d beats expected 4 matching model", obs_data.size());
        end
    endtask

    task automatic test_random;
        logic [2:0] seed;
        int         count, mode, abort_at, n;
        bit         ok;
        for (int it = 0; it < 25; it++) begin
            seed     = 3'($urandom);
            count    = $urandom_range(0, 20);
            mode     = $urandom_range(0, 2);
            abort_at = (count > 0 && ($urandom % 4) == 0) ? $urandom_range(1, count) : 0;
            n        = (abort_at != 0) ? abort_at : count;
            run_cmd(seed, 8'(count), mode, abort_at, 0);
            build_model(seed, n);
            ok = (obs_data.size() == n) && (timed_out == 1'b0);
            for (int i = 0; ok && i < n; i++)
                if (obs_data[i] !== exp_data[i] || obs_last[i] !== (i == count - 1) || obs_wrap[i] !== exp_wrap[i])
                    ok = 0;
            n_checks++;
            if (!ok) begin
                n_fail++;
                $display("FAIL rand%0d_seq: got %0d beats expected %0d (seed %0d count %0d abort %0d)",
                         it, obs_data.size(), n, seed, count, abort_at);
            end
            n_checks++;
            if (wrap_at_done !== exp_wrap_done || held_ok !== 1'b1 || cr_after !== 1'b1) begin
                n_fail++;
                $display("FAIL rand%0d_end: got wrap %b hold %b rdy %b expected %b 1 1", it, wrap_at_done, held_ok, cr_after, exp_wrap_done);
            end
            n_checks++;
            if ((n > 0) ? (done_cyc - last_hs_cyc !== 1) : (done_cyc !== 0 || n_valid !== 0)) begin
                n_fail++; $display("FAIL rand%0d_done: got done_cyc %0d last_hs %0d", it, done_cyc, last_hs_cyc);
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_period();
        test_stall();
        test_zero_seed();
        test_count8();
        test_count0();
        test_abort();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
